pipe_result_reader: RTL and testbench

Readback engine for the pipeline's 256 x 16 result memory. On a start pulse it reads a contiguous block of result words (the values the pipeline's store stage wrote at `mem[addr]`) through a single synchronous read port. It streams them out on a valid/ready interface, tagged with their memory address. It sits on the read side of the result memory, opposite the pipeline's write stage, and feeds result checkers or a host-side drain.

---
 rtl/pipe_result_reader.sv | 111 +++++++++++
 tb/tb_pipe_result_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_result_reader.sv
// Readback engine for the result memory: streams a contiguous, address-tagged
// block of words out of a 1-cycle-latency read port through a 2-entry buffer.
module pipe_result_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              fl_q;
  logic [ADDR_W-1:0] fl_addr_q;
  entry_t            fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q, occ_d;
  logic              push, pop;

  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = fl_q;
  assign occ_d     = occ_q + 2'(push) - 2'(pop);

  // Credit: buffered words plus the in-flight read, net of this cycle's pop,
  // must leave a free slot so the returning word always has a home.
  assign mem_re = (state_q == S_READ) && (rem_q != '0) &&
                  ((3'(occ_q) + 3'(fl_q)) < (3'd2 + 3'(pop)));

  assign mem_addr = mem_re    ? raddr_q               : '0;
  assign out_data = out_valid ? fifo_q[rd_ptr_q].data : '0;
  assign out_addr = out_valid ? fifo_q[rd_ptr_q].addr : '0;
  assign busy     = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done     = (state_q == S_FIN);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    raddr_d = raddr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = count;
          raddr_d = start_addr;
          state_d = (count == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        if (mem_re) begin
          rem_d   = rem_q - (ADDR_W+1)'(1);
          raddr_d = raddr_q + ADDR_W'(1);
          if (rem_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
        end
      end
      // Leave as soon as the final word is popped, so done follows it directly.
      S_DRAIN: begin
        if ((occ_d == 2'd0) && !fl_q) state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      raddr_q   <= '0;
      fl_q      <= 1'b0;
      fl_addr_q <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      raddr_q <= raddr_d;
      fl_q    <= mem_re;
      if (mem_re) fl_addr_q <= raddr_q;
      if (push)   wr_ptr_q  <= ~wr_ptr_q;
      if (pop)    rd_ptr_q  <= ~rd_ptr_q;
      occ_q   <= occ_d;
    end
  end

  // Storage needs no reset: it is only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push && !rst) fifo_q[wr_ptr_q] <= '{addr: fl_addr_q, data: mem_rdata};
  end
endmodule

// File: tb/tb_pipe_result_reader.sv
// Directed bench for pipe_result_reader with a behavioural 1-cycle read memory.
module tb_pipe_result_reader;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [AW-1:0] start_addr;
  logic [AW:0]   count;
  logic          busy, done, mem_re, out_valid;
  logic [AW-1:0] mem_addr, out_addr;
  logic [DW-1:0] mem_rdata, out_data;
  logic [DW-1:0] mem [256];
  int            nvec = 0;
  int            nerr = 0;

  pipe_result_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .busy(busy), .done(done), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle; inputs may then be driven, then #1 before sampling.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"},   32'(busy),      32'd0);
    chk({tag, "_done"},   32'(done),      32'd0);
    chk({tag, "_re"},     32'(mem_re),    32'd0);
    chk({tag, "_maddr"},  32'(mem_addr),  32'd0);
    chk({tag, "_valid"},  32'(out_valid), 32'd0);
    chk({tag, "_odata"},  32'(out_data),  32'd0);
    chk({tag, "_oaddr"},  32'(out_addr),  32'd0);
  endtask

  // Generic transfer: in-order address/data, stall stability, credit bound, one done.
  task automatic run_xfer(input string tag, input logic [AW-1:0] sa, input int cnt,
                          input int mode, input bit repulse);
    int got = 0, issued = 0, dones = 0;
    bit held = 1'b0;
    logic [AW-1:0] ha, ea;
    logic [DW-1:0] hd;
    start_addr = sa; count = cnt[AW:0]; start = 1'b1; out_ready = 1'b1;
    #1;
    for (int c = 1; c <= cnt * 4 + 20; c++) begin
      nxt();
      start      = repulse && (c == 4);
      start_addr = repulse ? (sa ^ 8'h5A) : sa;
      count      = repulse ? 9'd2 : cnt[AW:0];
      out_ready  = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      #1;
      if (held) begin
        chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
        chk({tag, "_hold_a"}, 32'(out_addr),  32'(ha));
        chk({tag, "_hold_d"}, 32'(out_data),  32'(hd));
      end
      if (out_valid && out_ready) begin
        ea = sa + got[AW-1:0];
        chk({tag, "_addr"}, 32'(out_addr), 32'(ea));
        chk({tag, "_data"}, 32'(out_data), 32'(mem[ea]));
        got++;
      end
      held = out_valid && !out_ready;
      ha = out_addr; hd = out_data;
      if (mem_re) begin
        issued++;
        chk({tag, "_credit"}, 32'((issued - got) <= 2), 32'd1);
      end
      if (done) begin
        dones++;
        break;
      end
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    start = 1'b0;
    chk({tag, "_nwords"}, 32'(got), 32'(cnt));
    chk({tag, "_ndone"},  32'(dones), 32'd1);
    for (int c = 0; c < 3; c++) begin
      nxt();
      chk({tag, "_post_done"},  32'(done),      32'd0);
      chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_post_busy"},  32'(busy),      32'd0);
    end
  endtask

  logic [DW-1:0] exp1 [6];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'((i * 37 + 11) ^ 16'hA500);
    mem[125] = 16'd8;  mem[126] = 16'd16; mem[127] = 16'd12;
    mem[128] = 16'd14; mem[129] = 16'd5;  mem[130] = 16'd25;
    mem[254] = 16'd1;  mem[255] = 16'd2;  mem[0] = 16'd3; mem[1] = 16'd4;
    exp1[0] = 16'd8; exp1[1] = 16'd16; exp1[2] = 16'd12;
    exp1[3] = 16'd14; exp1[4] = 16'd5; exp1[5] = 16'd25;

    rst = 1'b1; start = 1'b0; out_ready = 1'b1; start_addr = '0; count = '0;
    nxt(); nxt();
    #1;
    chk_idle_outs("reset");
    rst = 1'b0;

    // Basic 6-word transfer with exact cycle timing.
    nxt();
    start_addr = 8'd125; count = 9'd6; start = 1'b1;
    #1;
    for (int c = 1; c <= 11; c++) begin
      nxt();
      start = 1'b0;
      #1;
      if (c == 1) begin
        chk("t1_re1",    32'(mem_re),   32'd1);
        chk("t1_maddr1", 32'(mem_addr), 32'd125);
      end
      chk("t1_valid", 32'(out_valid), 32'(c >= 3 && c <= 8));
      if (c >= 3 && c <= 8) begin
        chk("t1_addr", 32'(out_addr), 32'(125 + c - 3));
        chk("t1_data", 32'(out_data), 32'(exp1[c-3]));
      end
      chk("t1_done", 32'(done), 32'(c == 9));
      chk("t1_busy", 32'(busy), 32'(c >= 1 && c <= 8));
    end

    run_xfer("stall", 8'd125, 6, 1, 1'b0);
    run_xfer("wrap", 8'd254, 4, 0, 1'b0);
    run_xfer("wrap_stall", 8'd254, 4, 1, 1'b0);
    run_xfer("repulse", 8'd125, 6, 0, 1'b1);

    // count = 0: no reads, no output, done in cycle 1.
    nxt();
    start_addr = 8'd40; count = 9'd0; start = 1'b1;
    #1;
    for (int c = 1; c <= 3; c++) begin
      nxt();
      start = 1'b0;
      #1;
      chk("c0_busy",  32'(busy),      32'd0);
      chk("c0_re",    32'(mem_re),    32'd0);
      chk("c0_valid", 32'(out_valid), 32'd0);
      chk("c0_done",  32'(done),      32'(c == 1));
    end

    run_xfer("full256", 8'd0, 256, 0, 1'b0);

    // Reset in cycle 5 of a 6-word transfer.
    nxt();
    start_addr = 8'd125; count = 9'd6; start = 1'b1;
    #1;
    for (int c = 1; c <= 5; c++) begin
      nxt();
      start = 1'b0;
      rst = (c == 5);
    end
    #1;
    chk("rst_re_pending", 32'(mem_re), 32'd1);
    nxt();
    rst = 1'b0;
    #1;
    chk_idle_outs("rst_c6");
    for (int c = 7; c <= 9; c++) begin
      nxt();
      chk("rst_no_valid", 32'(out_valid), 32'd0);
      chk("rst_no_done",  32'(done),      32'd0);
    end
    start_addr = 8'd125; count = 9'd1; start = 1'b1;
    #1;
    for (int c = 1; c <= 4; c++) begin
      nxt();
      start = 1'b0;
      #1;
      chk("rst_rs_valid", 32'(out_valid), 32'(c == 3));
      if (c == 3) begin
        chk("rst_rs_addr", 32'(out_addr), 32'd125);
        chk("rst_rs_data", 32'(out_data), 32'd8);
      end
      chk("rst_rs_done", 32'(done), 32'(c == 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
